// File: rtl/avalon_streaming_packer.sv
// Packs consecutive bytes of an 8-bit Avalon-ST stream into little-endian words.
// A flush emits the partial word, and aso_empty reports how many upper lanes are unused.
module avalon_streaming_packer #(
   parameter  int unsigned BYTES_PER_WORD = 4,
   localparam int unsigned EMPTY_W        = $clog2(BYTES_PER_WORD),
   localparam int unsigned DATA_W         = 8 * BYTES_PER_WORD
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               asi_valid,
   input  logic [7:0]         asi_data,
   output logic               asi_ready,
   output logic               aso_valid,
   output logic [DATA_W-1:0]  aso_data,
   output logic [EMPTY_W-1:0] aso_empty,
   input  logic               aso_ready,
   input  logic               flush,
   output logic               flush_ack,
   output logic [15:0]        word_count
);

   localparam int unsigned         ACC_W = 8 * (BYTES_PER_WORD - 1);
   localparam logic [EMPTY_W-1:0]  LAST  = EMPTY_W'(BYTES_PER_WORD - 1);

   logic [ACC_W-1:0]   acc_q,   acc_d;
   logic [EMPTY_W-1:0] cnt_q,   cnt_d;
   logic               valid_q, valid_d;
   logic [DATA_W-1:0]  data_q,  data_d;
   logic [EMPTY_W-1:0] empty_q, empty_d;
   logic               ack_q,   ack_d;
   logic [15:0]        wc_q,    wc_d;
   logic               out_free;
   logic               accept;

   // Last byte of a word needs a free holding register, so gate it on the held word alone.
   assign asi_ready = ~flush & ~((cnt_q == LAST) & valid_q);
   assign out_free  = ~valid_q | aso_ready;
   assign accept    = asi_valid & asi_ready;

   always_comb begin
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      valid_d = valid_q & ~aso_ready;
      data_d  = data_q;
      empty_d = empty_q;
      ack_d   = 1'b0;
      wc_d    = wc_q;
      if (accept) begin
         if (cnt_q == LAST) begin
            data_d  = {asi_data, acc_q};
            empty_d = '0;
            valid_d = 1'b1;
            cnt_d   = '0;
            acc_d   = '0;
            wc_d    = wc_q + 16'd1;
         end else begin
            acc_d[8*int'(cnt_q) +: 8] = asi_data;
            cnt_d                     = cnt_q + EMPTY_W'(1);
         end
      end else if (flush) begin
         if (cnt_q == '0) begin
            ack_d = 1'b1;
         end else if (out_free) begin
            // Lanes at or above cnt are always zero in acc, so zero-extension pads the word.
            data_d  = DATA_W'(acc_q);
            empty_d = EMPTY_W'(BYTES_PER_WORD - int'(cnt_q));
            valid_d = 1'b1;
            cnt_d   = '0;
            acc_d   = '0;
            wc_d    = wc_q + 16'd1;
            ack_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         empty_q <= '0;
         ack_q   <= 1'b0;
         wc_q    <= '0;
      end else begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         empty_q <= empty_d;
         ack_q   <= ack_d;
         wc_q    <= wc_d;
      end
   end

   assign aso_valid  = valid_q;
   assign aso_data   = data_q;
   assign aso_empty  = empty_q;
   assign flush_ack  = ack_q;
   assign word_count = wc_q;

endmodule

// File: tb/tb_avalon_streaming_packer.sv
// Directed bench for avalon_streaming_packer with 4-byte words.
// Delivered words are logged by a monitor and compared in order against hand-computed values.
module tb_avalon_streaming_packer;

   logic        clk = 1'b0;
   logic        reset;
   logic        asi_valid;
   logic [7:0]  asi_data;
   logic        asi_ready;
   logic        aso_valid;
   logic [31:0] aso_data;
   logic [1:0]  aso_empty;
   logic        aso_ready;
   logic        flush;
   logic        flush_ack;
   logic [15:0] word_count;

   int total = 0;
   int bad   = 0;
   logic [33:0] words_q[$];

   avalon_streaming_packer #(.BYTES_PER_WORD(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .asi_valid  (asi_valid),
      .asi_data   (asi_data),
      .asi_ready  (asi_ready),
      .aso_valid  (aso_valid),
      .aso_data   (aso_data),
      .aso_empty  (aso_empty),
      .aso_ready  (aso_ready),
      .flush      (flush),
      .flush_ack  (flush_ack),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   // Inputs change only at negedge, so at negedge+2 the handshake for the next posedge is settled.
   always @(negedge clk) begin
      #2;
      if (aso_valid && aso_ready) words_q.push_back({aso_empty, aso_data});
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic expect_word(input string tag, input logic [31:0] d, input logic [1:0] e);
      logic [33:0] w;
      if (words_q.size() > 0) w = words_q.pop_front();
      else                    w = '1;
      chk(tag, 64'(w), 64'({e, d}));
   endtask

   // Called at a negedge; returns at the negedge after the byte was accepted.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n         = 0;
      asi_valid = 1'b1;
      asi_data  = b;
      #1;
      while (!asi_ready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n == 50) chk("rdy_timeout", 64'(asi_ready), 64'd1);
      @(negedge clk);
      asi_valid = 1'b0;
   endtask

   task automatic idle(input int c);
      repeat (c) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      reset     = 1'b0;
      asi_valid = 1'b0;
      asi_data  = 8'h00;
      aso_ready = 1'b1;
      flush     = 1'b0;
      idle(3);
      chk("rst_valid", 64'(aso_valid), 64'd0);
      chk("rst_data",  64'(aso_data),  64'd0);
      chk("rst_empty", 64'(aso_empty), 64'd0);
      chk("rst_ack",   64'(flush_ack), 64'd0);
      chk("rst_wc",    64'(word_count), 64'd0);
      reset = 1'b1;
      #1;
      chk("rst_ready", 64'(asi_ready), 64'd1);
      idle(1);

      // Streaming at full rate
      for (int i = 1; i <= 4; i++) send_byte(8'(i));
      chk("t1_lat_valid", 64'(aso_valid), 64'd1);
      chk("t1_lat_data",  64'(aso_data),  64'h04030201);
      for (int i = 5; i <= 8; i++) send_byte(8'(i));
      chk("t1_w2_valid", 64'(aso_valid), 64'd1);
      idle(2);
      chk("t1_drained", 64'(aso_valid), 64'd0);
      chk("t1_wc", 64'(word_count), 64'd2);
      expect_word("t1_w1", 32'h04030201, 2'd0);
      expect_word("t1_w2", 32'h08070605, 2'd0);

      // Backpressure: first word held, input stalls at cnt=3
      aso_ready = 1'b0;
      for (int i = 'h11; i <= 'h17; i++) send_byte(8'(i));
      asi_valid = 1'b1;
      asi_data  = 8'h18;
      #1;
      chk("t2_stall_ready", 64'(asi_ready), 64'd0);
      chk("t2_hold_data",   64'(aso_data),  64'h14131211);
      idle(3);
      #1;
      chk("t2_hold_data2",  64'(aso_data),  64'h14131211);
      chk("t2_hold_valid",  64'(aso_valid), 64'd1);
      chk("t2_still_stall", 64'(asi_ready), 64'd0);
      aso_ready = 1'b1;
      send_byte(8'h18);
      idle(3);
      expect_word("t2_w1", 32'h14131211, 2'd0);
      expect_word("t2_w2", 32'h18171615, 2'd0);
      chk("t2_wc", 64'(word_count), 64'd4);

      // Partial flush
      send_byte(8'hAA);
      send_byte(8'hBB);
      flush = 1'b1;
      #1;
      chk("t3_flush_ready", 64'(asi_ready), 64'd0);
      @(negedge clk);
      flush = 1'b0;
      chk("t3_valid", 64'(aso_valid), 64'd1);
      chk("t3_data",  64'(aso_data),  64'h0000BBAA);
      chk("t3_empty", 64'(aso_empty), 64'd2);
      chk("t3_ack",   64'(flush_ack), 64'd1);
      idle(1);
      chk("t3_ack_low", 64'(flush_ack), 64'd0);
      idle(1);
      expect_word("t3_w", 32'h0000BBAA, 2'd2);
      chk("t3_wc", 64'(word_count), 64'd5);

      // Flush with nothing packed
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("t4_ack",   64'(flush_ack), 64'd1);
      chk("t4_valid", 64'(aso_valid), 64'd0);
      idle(1);
      chk("t4_ack_low", 64'(flush_ack), 64'd0);
      chk("t4_wc",      64'(word_count), 64'd5);
      chk("t4_noword",  64'(words_q.size()), 64'd0);

      // Async reset mid-pack, then mid-stall
      send_byte(8'h21);
      send_byte(8'h22);
      send_byte(8'h23);
      #1;
      reset = 1'b0;
      #1;
      chk("t5a_valid", 64'(aso_valid), 64'd0);
      chk("t5a_wc",    64'(word_count), 64'd0);
      @(negedge clk);
      reset     = 1'b1;
      aso_ready = 1'b0;
      for (int i = 'h31; i <= 'h35; i++) send_byte(8'(i));
      chk("t5b_pre_valid", 64'(aso_valid), 64'd1);
      #1;
      reset = 1'b0;
      #1;
      chk("t5b_valid", 64'(aso_valid), 64'd0);
      chk("t5b_data",  64'(aso_data),  64'd0);
      chk("t5b_empty", 64'(aso_empty), 64'd0);
      chk("t5b_ack",   64'(flush_ack), 64'd0);
      chk("t5b_wc",    64'(word_count), 64'd0);
      @(negedge clk);
      reset     = 1'b1;
      aso_ready = 1'b1;
      for (int i = 'h41; i <= 'h44; i++) send_byte(8'(i));
      idle(2);
      expect_word("t5_w", 32'h44434241, 2'd0);
      chk("t5_only", 64'(words_q.size()), 64'd0);
      chk("t5_wc",   64'(word_count), 64'd1);

      // word_count wrap, then flush loading while the held word drains
      force dut.wc_q = 16'hFFFF;
      #1;
      release dut.wc_q;
      chk("t6_forced", 64'(word_count), 64'hFFFF);
      aso_ready = 1'b0;
      for (int i = 'h51; i <= 'h54; i++) send_byte(8'(i));
      chk("t6_wrap", 64'(word_count), 64'd0);
      send_byte(8'h55);
      send_byte(8'h56);
      flush     = 1'b1;
      aso_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("t6_b2b_valid", 64'(aso_valid), 64'd1);
      chk("t6_b2b_data",  64'(aso_data),  64'h00005655);
      chk("t6_b2b_empty", 64'(aso_empty), 64'd2);
      chk("t6_b2b_ack",   64'(flush_ack), 64'd1);
      chk("t6_wc",        64'(word_count), 64'd1);
      idle(2);
      expect_word("t6_w1", 32'h54535251, 2'd0);
      expect_word("t6_w2", 32'h00005655, 2'd2);
      chk("t6_empty_q", 64'(words_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
